// File: rtl/block_word_reader_192.sv
// block_word_reader_192
// Reader side of the 192-bit saved-block register. A start pulse in IDLE
// captures block_in. The block is then streamed out as WORD_W-bit words,
// most significant word first, over a valid/ready handshake.
//
// Ports:
//   CLK        system clock, rising edge
//   RST        asynchronous active-low reset
//   start      capture block_in and begin streaming (honoured in IDLE only)
//   abort      synchronous cancel, highest priority, no done pulse
//   block_in   block sampled on the accepted start edge
//   word_out   current word (top WORD_W bits of the shift register)
//   word_valid word_out is valid (SEND state)
//   word_ready consumer accepts word_out this cycle
//   word_index index of word_out, 0 = most significant word
//   word_last  high with word_valid on the final word
//   busy       high while streaming
//   done       one-cycle pulse after the final word transfers
module block_word_reader_192 #(
    parameter int BLOCK_W = 192,
    parameter int WORD_W  = 32,
    parameter int IDX_W   = 3,
    localparam int NUM_WORDS = BLOCK_W / WORD_W
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               start,
    input  logic               abort,
    input  logic [BLOCK_W-1:0] block_in,
    output logic [WORD_W-1:0]  word_out,
    output logic               word_valid,
    input  logic               word_ready,
    output logic [IDX_W-1:0]   word_index,
    output logic               word_last,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    state_t             state_q, state_d;
    logic [BLOCK_W-1:0] shreg_q, shreg_d;
    logic [IDX_W-1:0]   idx_q,   idx_d;

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        idx_d   = idx_q;
        if (abort) begin
            // Abort beats start and any transfer presented this cycle.
            state_d = S_IDLE;
            shreg_d = '0;
            idx_d   = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        shreg_d = block_in;
                        idx_d   = '0;
                        state_d = S_SEND;
                    end
                end
                S_SEND: begin
                    if (word_ready) begin
                        if (idx_q == LAST_IDX) begin
                            state_d = S_DONE;
                        end else begin
                            shreg_d = {shreg_q[BLOCK_W-WORD_W-1:0], {WORD_W{1'b0}}};
                            idx_d   = idx_q + IDX_W'(1);
                        end
                    end
                end
                S_DONE: begin
                    // start here is dropped; it must be re-issued in IDLE.
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= S_IDLE;
            shreg_q <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            idx_q   <= idx_d;
        end
    end

    // Outputs decode only from state, index and shift register, so nothing
    // flows combinationally from word_ready to the output side.
    assign word_valid = (state_q == S_SEND);
    assign busy       = (state_q == S_SEND);
    assign done       = (state_q == S_DONE);
    assign word_out   = word_valid ? shreg_q[BLOCK_W-1 -: WORD_W] : '0;
    assign word_index = idx_q;
    assign word_last  = word_valid && (idx_q == LAST_IDX);

endmodule

// File: tb/tb_block_word_reader_192.sv
module tb_block_word_reader_192;

    logic         CLK = 1'b0;
    logic         RST = 1'b0;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic [191:0] block_in = '0;
    logic [31:0]  word_out;
    logic         word_valid;
    logic         word_ready = 1'b0;
    logic [2:0]   word_index;
    logic         word_last;
    logic         busy;
    logic         done;

    int checks = 0;
    int failures = 0;

    block_word_reader_192 dut (
        .CLK        (CLK),
        .RST        (RST),
        .start      (start),
        .abort      (abort),
        .block_in   (block_in),
        .word_out   (word_out),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .word_index (word_index),
        .word_last  (word_last),
        .busy       (busy),
        .done       (done)
    );

    always #5 CLK = ~CLK;

    // Reference model: an accepted start queues the six words of the block;
    // each handshake (without abort) retires the head; retiring the sixth
    // word schedules a done pulse for the following cycle.
    typedef struct {
        logic [31:0] w;
        int          idx;
    } exp_t;

    exp_t q[$];
    bit   pend_done = 0;
    bit   done_now  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            q.delete();
            pend_done = 0;
            done_now  = 0;
        end else if (abort) begin
            q.delete();
            pend_done = 0;
            done_now  = 0;
        end else begin
            if (start && q.size() == 0 && !pend_done && !done_now) begin
                for (int i = 0; i < 6; i++) begin
                    exp_t e;
                    e.w   = 32'((block_in >> (32 * (5 - i))) & 192'hFFFF_FFFF);
                    e.idx = i;
                    q.push_back(e);
                end
            end
            done_now  = pend_done;
            pend_done = 0;
        end
    end

    // Monitor: compares at the falling edge, away from the active edge.
    always @(negedge CLK) begin
        bit ev;
        ev = (q.size() > 0);
        chk("word_valid", 64'(word_valid), 64'(ev));
        chk("busy", 64'(busy), 64'(ev));
        chk("done", 64'(done), 64'(done_now));
        if (ev) begin
            chk("word_out", 64'(word_out), 64'(q[0].w));
            chk("word_index", 64'(word_index), 64'(q[0].idx));
            chk("word_last", 64'(word_last), 64'(q[0].idx == 5));
            if (word_ready && !abort) begin
                exp_t p;
                p = q.pop_front();
                if (p.idx == 5) pend_done = 1;
            end
        end else begin
            chk("word_last_idle", 64'(word_last), 64'(0));
        end
    end

    task automatic drv(input bit s, input bit a, input bit r);
        start      = s;
        abort      = a;
        word_ready = r;
        @(posedge CLK);
        #1;
    endtask

    localparam logic [191:0] BLK_SEQ =
        192'h00000001_00000002_00000003_00000004_00000005_00000006;

    initial begin
        // Reset state
        RST = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_word_out", 64'(word_out), 64'(0));
        chk("rst_valid", 64'(word_valid), 64'(0));
        chk("rst_index", 64'(word_index), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        RST = 1'b1;
        drv(0, 0, 0);

        // Basic stream with ready held high
        block_in = BLK_SEQ;
        drv(1, 0, 1);
        repeat (8) drv(0, 0, 1);

        // Backpressure at index 2
        drv(1, 0, 0);
        drv(0, 0, 1);
        drv(0, 0, 1);
        repeat (3) drv(0, 0, 0);
        repeat (6) drv(0, 0, 1);

        // Block isolation: new block and a second start during SEND
        drv(1, 0, 1);
        block_in = '1;
        drv(1, 0, 1);
        drv(1, 0, 1);
        start = 0;
        repeat (6) drv(0, 0, 1);

        // Abort at index 3, then stream 0xAAAA...
        block_in = BLK_SEQ;
        drv(1, 0, 1);
        repeat (3) drv(0, 0, 1);
        drv(0, 1, 1);
        chk("abort_valid", 64'(word_valid), 64'(0));
        block_in = {6{32'hAAAA_AAAA}};
        drv(1, 0, 1);
        repeat (8) drv(0, 0, 1);

        // Asynchronous reset while index 4 is presented
        block_in = BLK_SEQ;
        drv(1, 0, 1);
        repeat (4) drv(0, 0, 1);
        chk("pre_rst_index", 64'(word_index), 64'(4));
        #1 RST = 1'b0;
        #1;
        chk("mid_rst_word_out", 64'(word_out), 64'(0));
        chk("mid_rst_valid", 64'(word_valid), 64'(0));
        chk("mid_rst_index", 64'(word_index), 64'(0));
        chk("mid_rst_last", 64'(word_last), 64'(0));
        chk("mid_rst_busy", 64'(busy), 64'(0));
        chk("mid_rst_done", 64'(done), 64'(0));
        @(posedge CLK);
        #1 RST = 1'b1;
        drv(1, 0, 1);
        repeat (8) drv(0, 0, 1);

        // start during the DONE cycle is ignored, one cycle later accepted
        drv(1, 0, 1);
        repeat (6) drv(0, 0, 1);
        drv(1, 0, 1);
        chk("done_start_ignored", 64'(busy), 64'(0));
        drv(1, 0, 1);
        chk("idle_start_accepted", 64'(busy), 64'(1));
        repeat (7) drv(0, 0, 1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            block_in = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            drv(($urandom_range(0, 4) == 0), ($urandom_range(0, 40) == 0),
                ($urandom_range(0, 9) < 7));
        end

        // Drain and confirm every expected word was seen
        repeat (10) drv(0, 0, 1);
        chk("drain_empty", 64'(q.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/block_word_reader_192.md
Name: block_word_reader_192

Overview:
- Reader side of the 192-bit saved-block register.
- On a start pulse, captures a 192-bit block and streams it out as 32-bit words, most significant word first, over a valid/ready handshake.
- Feeds the SHA256 message-word path, which consumes words at its own rate.
- Supports word index, last-word flag, completion pulse and synchronous abort.

Parameters:
- BLOCK_W, 192, width of the block captured from the block register.
- WORD_W, 32, width of each streamed word; BLOCK_W must be an integer multiple of WORD_W.
- NUM_WORDS, BLOCK_W/WORD_W (6), words per block; derived, not to be overridden.
- IDX_W, 3, width of the word index; must satisfy 2^IDX_W >= NUM_WORDS.

Ports:
- CLK  input  1  system clock, all state updates on rising edge
- RST  input  1  asynchronous active-low reset
- start  input  1  one-cycle request to capture block_in and begin streaming; honoured only in IDLE
- abort  input  1  synchronous cancel; returns to IDLE without done
- block_in  input  BLOCK_W  block to be read, sampled on the accepted start edge
- word_out  output  WORD_W  current word
- word_valid  output  1  word_out is valid
- word_ready  input  1  consumer accepts word_out this cycle
- word_index  output  IDX_W  index of word_out, 0 = bits [191:160]
- word_last  output  1  high with word_valid when word_index == NUM_WORDS-1
- busy  output  1  high in SEND
- done  output  1  one-cycle pulse after the last word transfers

Behaviour:
- Reset (RST low, asynchronous):
  - state = IDLE; shift register and index cleared to 0.
  - word_out = 0, word_valid = 0, word_index = 0, word_last = 0, busy = 0, done = 0.
  - Applies immediately, including mid-stream; no done is produced.
- States: IDLE, SEND, DONE.
- IDLE:
  - word_valid = 0, busy = 0.
  - start=1 and abort=0 at an edge: shift register <= block_in, index <= 0, go to SEND.
  - Latency: word_valid and busy rise in the cycle after start, with word_out = block_in[191:160].
- SEND:
  - word_valid = 1; word_out = shift register [BLOCK_W-1 -: WORD_W].
  - Transfer = word_valid & word_ready at a rising edge.
  - No transfer: word_out, word_index and word_last hold stable. Consumer stalls of any length are allowed.
  - Transfer with index < NUM_WORDS-1: shift left by WORD_W (zero fill), index += 1.
  - Throughput: with word_ready held high, one word per cycle; 6 words in 6 consecutive cycles.
  - Transfer with index == NUM_WORDS-1: go to DONE.
  - start is ignored in SEND; the captured block is unaffected by later changes to block_in.
- DONE:
  - done = 1 for exactly this cycle; word_valid = 0, busy = 0.
  - Unconditionally returns to IDLE next cycle.
  - start during DONE is ignored; it must be re-issued in IDLE.
- abort:
  - Highest priority over start and transfer in any state.
  - Next state = IDLE, index = 0, shift register cleared, no done pulse.
  - A word presented in the abort cycle is counted as not transferred.
- Outputs are registered or decoded from state, index and shift register only; no combinational path from word_ready to word_valid or word_out.

Test Plan:
- Basic stream: block_in = 0x00000001_00000002_00000003_00000004_00000005_00000006, start, word_ready=1 -> words 1..6 on six consecutive cycles starting 1 cycle after start; word_index 0..5; word_last only on word 6; done pulses 1 cycle after last transfer; busy high exactly 6 cycles.
- Backpressure: same block, word_ready low for 3 cycles at index 2 -> word_out = 0x00000003 held stable, index 2 held; resume gives words 4..6; no word is duplicated or skipped.
- Block isolation: change block_in to all-ones and pulse start again during SEND -> streamed words still 1..6; no restart.
- Abort: abort asserted at index 3 -> word_valid low next cycle, no done; a new start with 0xAAAA... streams six 0xAAAAAAAA words from index 0.
- Reset mid-operation: RST low at index 4 -> all outputs 0 immediately (asynchronous); after release, state is IDLE and a start streams the full block.
- DONE-cycle start: start asserted in the done cycle is ignored (busy stays 0); start one cycle later is accepted normally.
